// File: rtl/sft_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sft_sched                                                     |
// | Purpose  : Round-robin frame scheduler for a 74HC595 chain. Arbitrates   |
// |            two requesters, serialises each frame into shift-byte,        |
// |            store and optional output-enable commands for the shift       |
// |            engine, and services a queued master-reset (clear) request.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sft_sched #(
    parameter int          NBYTE  = 4,
    parameter logic [15:0] TO_CYC = 16'd4095
) (
    input  logic               CLK_I,
    input  logic               RST_N_I,
    input  logic               clr_req,
    input  logic               req0_vld,
    input  logic [NBYTE*8-1:0] req0_data,
    input  logic               req0_oe_n,
    output logic               req0_ack,
    input  logic               req1_vld,
    input  logic [NBYTE*8-1:0] req1_data,
    input  logic               req1_oe_n,
    output logic               req1_ack,
    output logic               sft_vld,
    output logic [1:0]         sft_cmd,
    output logic               sft_cmd_oen,
    output logic [7:0]         sft_din,
    input  logic               sft_done,
    output logic               busy,
    output logic               gnt,
    output logic               frame_done,
    output logic               err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] c_CMD_CLR   = 2'b00;
    localparam logic [1:0] c_CMD_SHIFT = 2'b01;
    localparam logic [1:0] c_CMD_STORE = 2'b10;
    localparam logic [1:0] c_CMD_OE    = 2'b11;

    // Command-list positions: 0..NBYTE-1 shift bytes, then store, then OE.
    localparam logic [3:0] c_IDX_STORE = 4'(NBYTE);
    localparam logic [3:0] c_IDX_OE    = 4'(NBYTE + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_clr_pend;
    logic               r_last;
    logic               r_oe_cur;
    logic               r_gnt;
    logic [NBYTE*8-1:0] r_buf;
    logic               r_oe_n;
    logic               r_is_clr;
    logic [3:0]         r_idx;
    logic [15:0]        r_tcnt;

    logic               w_sel0;
    logic               w_sel1;
    logic               w_adv;
    logic               w_oe_step;
    logic [1:0]         w_cmd;

    assign busy      = (r_state != S_IDLE);
    assign gnt       = r_gnt;
    assign w_oe_step = (r_oe_n != r_oe_cur);

    // Current command list entry: clear, shift byte, store, or output enable.
    always_comb begin
        w_cmd = c_CMD_OE;
        if (r_is_clr) begin
            w_cmd = c_CMD_CLR;
        end else if (r_idx < c_IDX_STORE) begin
            w_cmd = c_CMD_SHIFT;
        end else if (r_idx == c_IDX_STORE) begin
            w_cmd = c_CMD_STORE;
        end
    end

    // State register.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration and command strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sel0      = 1'b0;
        w_sel1      = 1'b0;
        w_adv       = 1'b0;
        req0_ack    = 1'b0;
        req1_ack    = 1'b0;
        sft_vld     = 1'b0;
        sft_cmd     = 2'b00;
        sft_cmd_oen = 1'b0;
        sft_din     = 8'h00;
        frame_done  = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_clr_pend) begin
                    w_state_nxt = S_ISSUE;
                end else if (req0_vld && (!req1_vld || r_last)) begin
                    w_sel0      = 1'b1;
                    req0_ack    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (req1_vld) begin
                    w_sel1      = 1'b1;
                    req1_ack    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sft_vld     = 1'b1;
                sft_cmd     = w_cmd;
                sft_din     = (w_cmd == c_CMD_SHIFT) ? r_buf[NBYTE*8-1 -: 8] : 8'h00;
                sft_cmd_oen = (w_cmd == c_CMD_OE) ? r_oe_n : 1'b0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (sft_done) begin
                    if (r_is_clr) begin
                        w_state_nxt = S_DONE;
                    end else if (r_idx < c_IDX_STORE) begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else if ((r_idx == c_IDX_STORE) && w_oe_step) begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (r_tcnt == 16'd0) begin
                    err         = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame buffer, list index, timeout counter and arbitration bookkeeping.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            r_clr_pend <= 1'b0;
            r_last     <= 1'b1;
            r_oe_cur   <= 1'b1;
            r_gnt      <= 1'b0;
            r_buf      <= '0;
            r_oe_n     <= 1'b1;
            r_is_clr   <= 1'b0;
            r_idx      <= 4'd0;
            r_tcnt     <= 16'd0;
        end else begin
            // A clear that arrives in the same cycle it is served stays queued.
            if ((r_state == S_IDLE) && r_clr_pend) begin
                r_clr_pend <= clr_req;
            end else if (clr_req) begin
                r_clr_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_clr_pend) begin
                        r_is_clr <= 1'b1;
                        r_idx    <= 4'd0;
                    end else if (w_sel0) begin
                        r_buf    <= req0_data;
                        r_oe_n   <= req0_oe_n;
                        r_gnt    <= 1'b0;
                        r_last   <= 1'b0;
                        r_is_clr <= 1'b0;
                        r_idx    <= 4'd0;
                    end else if (w_sel1) begin
                        r_buf    <= req1_data;
                        r_oe_n   <= req1_oe_n;
                        r_gnt    <= 1'b1;
                        r_last   <= 1'b1;
                        r_is_clr <= 1'b0;
                        r_idx    <= 4'd0;
                    end
                end
                S_ISSUE: begin
                    r_tcnt <= TO_CYC;
                end
                S_WAIT: begin
                    if (w_adv) begin
                        // Next byte moves to the top so din always reads the MSB slot.
                        if (r_idx < c_IDX_STORE) begin
                            r_buf <= r_buf << 8;
                        end
                        r_idx <= r_idx + 4'd1;
                    end else if (r_tcnt != 16'd0) begin
                        r_tcnt <= r_tcnt - 16'd1;
                    end
                end
                S_DONE: begin
                    // Index only reaches the OE slot when cmd 11 was actually issued.
                    if (!r_is_clr && (r_idx == c_IDX_OE)) begin
                        r_oe_cur <= r_oe_n;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sft_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sft_sched                                                  |
// | Purpose  : Scoreboard bench for sft_sched: directed frames, contention,  |
// |            clear priority, timeout and reset-mid-frame scenarios.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sft_sched;

    localparam int c_NBYTE = 4;

    localparam logic [2:0] K_VLD  = 3'd1;
    localparam logic [2:0] K_ACK0 = 3'd2;
    localparam logic [2:0] K_ACK1 = 3'd3;
    localparam logic [2:0] K_FD   = 3'd4;
    localparam logic [2:0] K_ERR  = 3'd5;

    logic        clk;
    logic        RST_N_I;
    logic        clr_req;
    logic        req0_vld;
    logic [31:0] req0_data;
    logic        req0_oe_n;
    logic        req0_ack;
    logic        req1_vld;
    logic [31:0] req1_data;
    logic        req1_oe_n;
    logic        req1_ack;
    logic        sft_vld;
    logic [1:0]  sft_cmd;
    logic        sft_cmd_oen;
    logic [7:0]  sft_din;
    logic        sft_done;
    logic        busy;
    logic        gnt;
    logic        frame_done;
    logic        err;

    int          checks;
    int          errors;
    int          cyc;
    int          vld_cnt;
    logic        eng_en;
    logic        m_oe_cur;
    logic [14:0] q[$];

    sft_sched #(
        .NBYTE (c_NBYTE),
        .TO_CYC(16'd10)
    ) u_dut (
        .CLK_I      (clk),
        .RST_N_I    (RST_N_I),
        .clr_req    (clr_req),
        .req0_vld   (req0_vld),
        .req0_data  (req0_data),
        .req0_oe_n  (req0_oe_n),
        .req0_ack   (req0_ack),
        .req1_vld   (req1_vld),
        .req1_data  (req1_data),
        .req1_oe_n  (req1_oe_n),
        .req1_ack   (req1_ack),
        .sft_vld    (sft_vld),
        .sft_cmd    (sft_cmd),
        .sft_cmd_oen(sft_cmd_oen),
        .sft_din    (sft_din),
        .sft_done   (sft_done),
        .busy       (busy),
        .gnt        (gnt),
        .frame_done (frame_done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [14:0] mk(input logic [2:0] k, input logic [1:0] c,
                                       input logic [7:0] d, input logic o, input logic g);
        return {k, c, d, o, g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected event list for one frame, tracking the output-enable level.
    task automatic exp_frame(input logic who, input logic [31:0] data, input logic oe_n);
        logic [31:0] d;
        d = data;
        q.push_back(mk(who ? K_ACK1 : K_ACK0, 2'b00, 8'h00, 1'b0, 1'b0));
        for (int k = 0; k < c_NBYTE; k++) begin
            q.push_back(mk(K_VLD, 2'b01, d[31-8*k -: 8], 1'b0, who));
        end
        q.push_back(mk(K_VLD, 2'b10, 8'h00, 1'b0, who));
        if (oe_n != m_oe_cur) begin
            q.push_back(mk(K_VLD, 2'b11, 8'h00, oe_n, who));
            m_oe_cur = oe_n;
        end
        q.push_back(mk(K_FD, 2'b00, 8'h00, 1'b0, 1'b0));
    endtask

    // Requester handshake: hold vld until ack, drop it the following cycle.
    task automatic send(input logic who, input logic [31:0] data, input logic oe_n);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (who) begin
            req1_vld = 1'b1; req1_data = data; req1_oe_n = oe_n;
        end else begin
            req0_vld = 1'b1; req0_data = data; req0_oe_n = oe_n;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((who && req1_ack) || (!who && req0_ack)) got = 1'b1;
        end
        check("ack_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (who) req1_vld = 1'b0;
        else     req0_vld = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic check_quiet(input string name);
        check(name, {18'd0, sft_vld, sft_cmd, sft_cmd_oen, sft_din, busy, gnt,
                     frame_done, err, req0_ack, req1_ack}, 32'd0);
    endtask

    // Shift-engine model: done pulse three cycles after each strobe.
    initial begin
        int eng_cnt;
        eng_cnt  = 0;
        sft_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!eng_en)      eng_cnt = 0;
            else if (sft_vld) eng_cnt = 3;
            @(posedge clk); #1;
            sft_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) sft_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT event and checks timing.
    initial begin
        logic [14:0] obs;
        logic [14:0] expv;
        logic [2:0]  kind;
        logic [2:0]  prev_kind;
        logic        prev_vld;
        logic        busy_next;
        int          nev;
        int          done_cyc;
        int          vld_cyc;
        int          ev_cyc;
        prev_kind = 3'd0;
        prev_vld  = 1'b0;
        busy_next = 1'b0;
        done_cyc  = 0;
        vld_cyc   = 0;
        ev_cyc    = 0;
        vld_cnt   = 0;
        forever begin
            @(negedge clk);
            if (busy_next) begin
                check("busy_after_end", 32'(busy), 32'd0);
                busy_next = 1'b0;
            end
            if (sft_done) done_cyc = cyc;
            nev = int'(sft_vld) + int'(req0_ack) + int'(req1_ack) + int'(frame_done) + int'(err);
            if (sft_vld) begin
                check("vld_spacing", 32'(prev_vld), 32'd0);
                vld_cnt = vld_cnt + 1;
            end
            prev_vld = sft_vld;
            if (nev > 1) begin
                check("single_event", 32'(nev), 32'd1);
            end else if (nev == 1) begin
                kind = sft_vld ? K_VLD : req0_ack ? K_ACK0 : req1_ack ? K_ACK1 :
                       frame_done ? K_FD : K_ERR;
                if (kind == K_VLD) obs = mk(kind, sft_cmd, sft_din, sft_cmd_oen, gnt);
                else               obs = mk(kind, 2'b00, 8'h00, 1'b0, 1'b0);
                if (q.size() == 0) begin
                    check("unexpected_event", 32'(obs), 32'd0);
                end else begin
                    expv = q.pop_front();
                    check("event", 32'(obs), 32'(expv));
                end
                if (kind == K_VLD) begin
                    if (prev_kind == K_ACK0 || prev_kind == K_ACK1)
                        check("ack_to_vld", 32'(cyc - ev_cyc), 32'd1);
                    else if (prev_kind == K_VLD)
                        check("done_to_vld", 32'(cyc - done_cyc), 32'd1);
                    vld_cyc = cyc;
                end else if (kind == K_FD) begin
                    check("done_to_fd", 32'(cyc - done_cyc), 32'd1);
                    check("busy_at_fd", 32'(busy), 32'd1);
                    busy_next = 1'b1;
                end else if (kind == K_ERR) begin
                    check("err_delay", 32'(cyc - vld_cyc), 32'd11);
                    busy_next = 1'b1;
                end
                prev_kind = kind;
                ev_cyc    = cyc;
            end
        end
    end

    initial begin
        bit got;
        int base;
        checks    = 0;
        errors    = 0;
        eng_en    = 1'b1;
        m_oe_cur  = 1'b1;
        RST_N_I   = 1'b0;
        clr_req   = 1'b0;
        req0_vld  = 1'b0;
        req0_data = 32'h0;
        req0_oe_n = 1'b1;
        req1_vld  = 1'b0;
        req1_data = 32'h0;
        req1_oe_n = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_outputs");
        @(posedge clk); #1;
        RST_N_I = 1'b1;
        repeat (2) @(posedge clk);

        // Contention: both held valid, grants alternate starting with requester 0.
        exp_frame(1'b0, 32'h01020304, 1'b1);
        exp_frame(1'b1, 32'h11223344, 1'b1);
        exp_frame(1'b0, 32'h01020304, 1'b1);
        @(posedge clk); #1;
        req0_vld = 1'b1; req0_data = 32'h01020304; req0_oe_n = 1'b1;
        req1_vld = 1'b1; req1_data = 32'h11223344; req1_oe_n = 1'b1;
        base = 0;
        for (int i = 0; i < 400 && base < 3; i++) begin
            @(negedge clk);
            if (req0_ack || req1_ack) base = base + 1;
        end
        check("contention_acks", 32'(base), 32'd3);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        drain("drain_contention", 300);

        // Single frame with output-enable step.
        exp_frame(1'b0, 32'hA1B2C3D4, 1'b0);
        send(1'b0, 32'hA1B2C3D4, 1'b0);
        drain("drain_oe_step", 200);

        // Same frame again: OE already at requested level, five strobes only.
        base = vld_cnt;
        exp_frame(1'b0, 32'hA1B2C3D4, 1'b0);
        send(1'b0, 32'hA1B2C3D4, 1'b0);
        drain("drain_oe_skip", 200);
        check("repeat_vld_count", 32'(vld_cnt - base), 32'd5);

        // Clear pulsed mid-frame with requester 1 waiting: clear served first.
        exp_frame(1'b0, 32'h55667788, 1'b0);
        q.push_back(mk(K_VLD, 2'b00, 8'h00, 1'b0, 1'b0));
        q.push_back(mk(K_FD, 2'b00, 8'h00, 1'b0, 1'b0));
        exp_frame(1'b1, 32'h99AABBCC, 1'b0);
        send(1'b0, 32'h55667788, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        clr_req = 1'b1;
        req1_vld = 1'b1; req1_data = 32'h99AABBCC; req1_oe_n = 1'b0;
        @(posedge clk); #1;
        clr_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req1_ack) got = 1'b1;
        end
        check("clr_req1_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_vld = 1'b0;
        drain("drain_clear", 200);

        // Timeout: engine silent, err 11 cycles after the strobe.
        eng_en = 1'b0;
        q.push_back(mk(K_ACK0, 2'b00, 8'h00, 1'b0, 1'b0));
        q.push_back(mk(K_VLD, 2'b01, 8'hDE, 1'b0, 1'b0));
        q.push_back(mk(K_ERR, 2'b00, 8'h00, 1'b0, 1'b0));
        send(1'b0, 32'hDEADBEEF, 1'b0);
        drain("drain_timeout", 100);
        check("idle_after_timeout", 32'(busy), 32'd0);
        eng_en = 1'b1;
        repeat (2) @(posedge clk);

        // Reset during WAIT of byte index 2.
        q.push_back(mk(K_ACK0, 2'b00, 8'h00, 1'b0, 1'b0));
        q.push_back(mk(K_VLD, 2'b01, 8'hCA, 1'b0, 1'b0));
        q.push_back(mk(K_VLD, 2'b01, 8'hFE, 1'b0, 1'b0));
        q.push_back(mk(K_VLD, 2'b01, 8'hF0, 1'b0, 1'b0));
        send(1'b0, 32'hCAFEF00D, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (sft_vld && sft_din == 8'hF0) got = 1'b1;
        end
        check("reach_byte2", 32'(got), 32'd1);
        @(posedge clk); #1;
        eng_en  = 1'b0;
        RST_N_I = 1'b0;
        @(posedge clk); #1;
        RST_N_I = 1'b1;
        m_oe_cur = 1'b1;
        @(negedge clk);
        check_quiet("post_reset_outputs");
        repeat (20) @(negedge clk);
        check("post_reset_pending", 32'(q.size()), 32'd0);
        q.delete();
        eng_en = 1'b1;
        repeat (2) @(posedge clk);

        // Fresh frame after reset: OE level back to disabled, so cmd 11 issued.
        exp_frame(1'b0, 32'h0F1E2D3C, 1'b0);
        send(1'b0, 32'h0F1E2D3C, 1'b0);
        drain("drain_after_reset", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
